// File: rtl/wb_sdr_pkg.sv
// Shared Wishbone/SDRAM front-end definitions: cycle-type codes and arbiter state.
package wb_sdr_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_sdr_arbiter_if.sv
// Bundle of the NM master-side Wishbone ports and the single controller-side port.
interface wb_sdr_arbiter_if
  import wb_sdr_pkg::*;
#(
    parameter int NM = 4,
    parameter int DW = 32,
    parameter int AW = 26
) ();
    localparam int SW = DW / 8;

    // Wishbone handshake: a beat moves on the cycle where cyc & stb & ack are all
    // high; cyc framing the whole transaction is what keeps the grant locked.
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*AW-1:0] m_addr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM*3-1:0]  m_cti_i;
    logic [NM-1:0]    m_ack_o;
    logic [DW-1:0]    m_dat_o;

    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_we_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic [2:0]       s_cti_o;
    logic             s_ack_i;
    logic [DW-1:0]    s_dat_i;

    logic [NM-1:0]    gnt_o;
    logic             tmo_o;
    arb_state_t       state_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
        input  s_ack_i, s_dat_i,
        output m_ack_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
        output gnt_o, tmo_o, state_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
        output s_ack_i, s_dat_i,
        input  m_ack_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
        input  gnt_o, tmo_o, state_o
    );

endinterface

// File: rtl/wb_sdr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit above 'last', wrapping.
module rr_pick #(
    parameter int NM = 4,
    parameter int LW = 2
) (
    input  logic [NM-1:0] req,
    input  logic [LW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic [LW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= NM; i++) begin
            j = (int'(last) + i) % NM;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = LW'(j);
            end
        end
    end

endmodule

// File: rtl/wb_sdr_arbiter.sv
// Round-robin Wishbone arbiter in front of sdrc_top; grant is held for a whole cyc.
// Optional ack timeout abort is built when WB_ARB_TIMEOUT_EN is defined.
module wb_sdr_arbiter
  import wb_sdr_pkg::*;
#(
    parameter int NM  = 4,
    parameter int DW  = 32,
    parameter int AW  = 26,
    parameter int TMO = 255
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    wb_sdr_arbiter_if.slave bus
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    if (NM < 2 || NM > 8 || TMO < 1) begin : g_bad_cfg
        $error("wb_sdr_arbiter: NM must be 2..8 and TMO at least 1");
    end

    arb_state_t    state_q, state_d;
    logic [NM-1:0] gnt_q;
    logic [LW-1:0] gidx_q;
    logic [LW-1:0] last_q;
    logic [NM-1:0] req;
    logic [NM-1:0] pick_gnt;
    logic [LW-1:0] pick_idx;
    logic          cyc_own;
    logic          tmo_fire;
    logic          own;

    rr_pick #(.NM(NM), .LW(LW)) u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign cyc_own = bus.m_cyc_i[gidx_q];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] cnt_q;
    logic [NM-1:0] blk_q;

    // Count stalled strobe cycles; the abort fires in the cycle the count reaches TMO.
    assign tmo_fire = (state_q == BUSY) && (cnt_q == CW'(TMO));
    assign req      = bus.m_cyc_i & ~blk_q;

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q <= '0;
            blk_q <= '0;
        end else begin
            if (state_q == IDLE || bus.s_ack_i) begin
                cnt_q <= '0;
            end else if (bus.s_stb_o) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // An aborted master stays blocked until it lets go of cyc.
            blk_q <= (blk_q & bus.m_cyc_i) | (tmo_fire ? gnt_q : '0);
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign req      = bus.m_cyc_i;
`endif

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= LW'(NM - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == BUSY) begin
                gnt_q  <= pick_gnt;
                gidx_q <= pick_idx;
            end else if (state_q == BUSY && state_d == IDLE) begin
                gnt_q  <= '0;
                last_q <= gidx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = BUSY;
            BUSY:    if (!cyc_own || tmo_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bus mux is gated by the owner's live cyc so s_cyc_o drops in the same cycle.
    always_comb begin
        own          = (state_q == BUSY) && cyc_own && !tmo_fire;
        bus.s_cyc_o  = own;
        bus.s_stb_o  = own && bus.m_stb_i[gidx_q];
        bus.s_we_o   = own && bus.m_we_i[gidx_q];
        bus.s_addr_o = own ? bus.m_addr_i[gidx_q*AW +: AW] : '0;
        bus.s_dat_o  = own ? bus.m_dat_i[gidx_q*DW +: DW] : '0;
        bus.s_sel_o  = own ? bus.m_sel_i[gidx_q*SW +: SW] : '0;
        bus.s_cti_o  = own ? bus.m_cti_i[gidx_q*3 +: 3] : '0;
        bus.m_ack_o  = gnt_q & {NM{bus.s_ack_i}};
        bus.m_dat_o  = bus.s_dat_i;
        bus.gnt_o    = gnt_q;
        bus.tmo_o    = tmo_fire;
        bus.state_o  = state_q;
    end

endmodule

// File: tb/tb_wb_sdr_arbiter.sv
// Directed bench for wb_sdr_arbiter with a small registered-ack SDRAM model.
// Build with WB_ARB_TIMEOUT_EN to exercise the timeout abort (TMO=16).
module tb_wb_sdr_arbiter;
  import wb_sdr_pkg::*;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wb_sdr_arbiter_if #(.NM(NM), .DW(DW), .AW(AW)) bus ();

  wb_sdr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TMO(TMO)) dut (
    .sys_clk (clk),
    .RESETN  (rst_n),
    .bus     (bus)
  );

  // ---------------- SDRAM model ----------------
  logic          ack_q;
  logic          ack_force;
  logic          ack_stall;
  logic [DW-1:0] rdat_q;
  logic [DW-1:0] mem [0:1023];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q <= bus.s_cyc_o & bus.s_stb_o & ~ack_q & ~ack_stall;
      if (bus.s_cyc_o && bus.s_stb_o && !ack_q && !ack_stall) begin
        if (bus.s_we_o) mem[bus.s_addr_o[9:0]] <= bus.s_dat_o;
        rdat_q <= mem[bus.s_addr_o[9:0]];
      end
    end
  end

  assign bus.s_ack_i = ack_q | ack_force;
  assign bus.s_dat_i = rdat_q;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_masters();
    bus.m_cyc_i  = '0;
    bus.m_stb_i  = '0;
    bus.m_we_i   = '0;
    bus.m_addr_i = '0;
    bus.m_dat_i  = '0;
    bus.m_sel_i  = '0;
    bus.m_cti_i  = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ack_stall = 1'b0;
    clear_masters();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input int k, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] cti);
    bus.m_cyc_i[k]          = 1'b1;
    bus.m_stb_i[k]          = 1'b1;
    bus.m_we_i[k]           = we;
    bus.m_addr_i[k*AW +: AW] = a;
    bus.m_dat_i[k*DW +: DW]  = d;
    bus.m_sel_i[k*SW +: SW]  = '1;
    bus.m_cti_i[k*3 +: 3]    = cti;
  endtask

  task automatic release_m(input int k);
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
  endtask

  // Classic single transfer for master k; waits (bounded) for its ack.
  task automatic xfer(input int k, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [DW-1:0] rd);
    int n;
    drive(k, we, a, d, CTI_CLASSIC);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_ack_o[k] && n < 20);
    check("xfer_ack_only_owner", 64'(bus.m_ack_o), 64'(1) << k);
    rd = bus.m_dat_o;
    release_m(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] rd;
    logic [3:0]    exp_gnt [0:8];
    int            n;
    int            beats;
    logic          gnt2_early;
    logic          ack2_early;
    logic          tmo_seen;
    logic [AW-1:0] baddr;
    logic [DW-1:0] bdat;

    rst_n     = 1'b0;
    ack_force = 1'b0;
    ack_stall = 1'b0;
    clear_masters();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_gnt", 64'(bus.gnt_o), 64'(0));
    check("rst_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    check("rst_s_stb", 64'(bus.s_stb_o), 64'(0));
    check("rst_m_ack", 64'(bus.m_ack_o), 64'(0));
    check("rst_tmo", 64'(bus.tmo_o), 64'(0));
    check("rst_state", 64'(bus.state_o), 64'(IDLE));
    rst_n = 1'b1;

    // Controller ack while idle must not reach any master
    @(negedge clk);
    ack_force = 1'b1;
    #1;
    check("idle_ack_ignored", 64'(bus.m_ack_o), 64'(0));
    ack_force = 1'b0;

    // Test 1: master 0 classic write then readback
    @(negedge clk);
    drive(0, 1'b1, 26'h0000100, 32'hDEADBEEF, CTI_CLASSIC);
    @(negedge clk);
    check("t1_gnt", 64'(bus.gnt_o), 64'(4'b0001));
    check("t1_s_cyc", 64'(bus.s_cyc_o), 64'(1));
    check("t1_s_we", 64'(bus.s_we_o), 64'(1));
    check("t1_s_addr", 64'(bus.s_addr_o), 64'(26'h0000100));
    check("t1_s_dat", 64'(bus.s_dat_o), 64'(32'hDEADBEEF));
    check("t1_s_sel", 64'(bus.s_sel_o), 64'(4'hF));
    check("t1_no_ack_yet", 64'(bus.m_ack_o), 64'(0));
    @(negedge clk);
    check("t1_ack", 64'(bus.m_ack_o), 64'(4'b0001));
    release_m(0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    xfer(0, 1'b0, 26'h0000100, '0, rd);
    check("t1_readback", 64'(rd), 64'(exp_q.pop_front()));

    // Test 2: all masters request; each drops cyc as soon as it sees its grant
    @(negedge clk);
    do_reset();
    bus.m_cyc_i = 4'b1111;
    exp_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t2_gnt_order", 64'(bus.gnt_o), 64'(exp_gnt[i]));
      check("t2_s_cyc", 64'(bus.s_cyc_o), 64'(exp_gnt[i] != 4'b0000));
      bus.m_cyc_i = ~bus.gnt_o;
    end
    clear_masters();

    // Test 3: master 1 8-beat burst while master 2 waits with a read
    @(negedge clk);
    do_reset();
    baddr = 26'h0000200;
    bdat  = 32'hB000_0000;
    drive(1, 1'b1, baddr, bdat, CTI_INCR);
    drive(2, 1'b0, 26'h0000200, '0, CTI_CLASSIC);
    exp_q.push_back(32'hB000_0000);
    beats      = 0;
    gnt2_early = 1'b0;
    ack2_early = 1'b0;
    n          = 0;
    while (beats < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.gnt_o[2]) gnt2_early = 1'b1;
      if (bus.m_ack_o[2]) ack2_early = 1'b1;
      if (bus.m_ack_o[1]) begin
        check("t3_burst_ack_owner", 64'(bus.m_ack_o), 64'(4'b0010));
        beats++;
        if (beats == 8) begin
          release_m(1);
        end else begin
          baddr = baddr + 1'b1;
          bdat  = bdat + 1'b1;
          drive(1, 1'b1, baddr, bdat, (beats == 7) ? CTI_EOB : CTI_INCR);
        end
      end
    end
    check("t3_beats", 64'(beats), 64'(8));
    check("t3_no_gnt2_in_burst", 64'(gnt2_early), 64'(0));
    check("t3_no_ack2_in_burst", 64'(ack2_early), 64'(0));
    #1;
    check("t3_s_cyc_falls_same_cycle", 64'(bus.s_cyc_o), 64'(0));
    @(negedge clk);
    check("t3_idle_gap", 64'(bus.gnt_o), 64'(0));
    @(negedge clk);
    check("t3_gnt2", 64'(bus.gnt_o), 64'(4'b0100));
    n = 0;
    while (!bus.m_ack_o[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_ack2", 64'(bus.m_ack_o), 64'(4'b0100));
    check("t3_read_beat0", 64'(bus.m_dat_o), 64'(exp_q.pop_front()));
    release_m(2);

    // Test 4: reset in the middle of a master 1 burst
    @(negedge clk);
    do_reset();
    drive(1, 1'b1, 26'h0000300, 32'h1234_0000, CTI_INCR);
    beats = 0;
    n     = 0;
    while (beats < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.m_ack_o[1]) beats++;
    end
    check("t4_acks_before_reset", 64'(beats), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_gnt", 64'(bus.gnt_o), 64'(0));
    check("t4_async_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    bus.m_cyc_i[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_master0_first", 64'(bus.gnt_o), 64'(4'b0001));
    clear_masters();

    // Test 6: master 0 drops cyc in the same cycle master 2 raises it
    @(negedge clk);
    do_reset();
    bus.m_cyc_i[0] = 1'b1;
    @(negedge clk);
    check("t6_gnt0", 64'(bus.gnt_o), 64'(4'b0001));
    bus.m_cyc_i[0] = 1'b0;
    drive(2, 1'b0, 26'h0000100, '0, CTI_CLASSIC);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("t6_idle_gap", 64'(bus.gnt_o), 64'(0));
    @(negedge clk);
    check("t6_gnt2", 64'(bus.gnt_o), 64'(4'b0100));
    n = 0;
    while (!bus.m_ack_o[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_ack_only_m2", 64'(bus.m_ack_o), 64'(4'b0100));
    check("t6_read", 64'(bus.m_dat_o), 64'(exp_q.pop_front()));
    release_m(2);

`ifdef WB_ARB_TIMEOUT_EN
    // Test 5: stalled master 3 is aborted and blocked until it drops cyc
    @(negedge clk);
    do_reset();
    ack_stall = 1'b1;
    drive(3, 1'b0, 26'h0000100, '0, CTI_CLASSIC);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tmo_o && n < 40);
    check("t5_tmo_cycle", 64'(n), 64'(TMO + 1));
    check("t5_s_cyc_forced_low", 64'(bus.s_cyc_o), 64'(0));
    bus.m_cyc_i[0] = 1'b1;
    @(negedge clk);
    check("t5_tmo_one_cycle", 64'(bus.tmo_o), 64'(0));
    check("t5_idle_after_abort", 64'(bus.gnt_o), 64'(0));
    @(negedge clk);
    check("t5_gnt0_not_3", 64'(bus.gnt_o), 64'(4'b0001));
    bus.m_cyc_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_m3_blocked", 64'(bus.gnt_o), 64'(0));
    release_m(3);
    @(negedge clk);
    bus.m_cyc_i[3] = 1'b1;
    @(negedge clk);
    check("t5_m3_regranted", 64'(bus.gnt_o), 64'(4'b1000));
    clear_masters();
    ack_stall = 1'b0;
`else
    // Without the timeout a stalled owner keeps its grant and tmo_o stays low
    @(negedge clk);
    do_reset();
    ack_stall = 1'b1;
    drive(3, 1'b0, 26'h0000100, '0, CTI_CLASSIC);
    tmo_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tmo_o) tmo_seen = 1'b1;
    end
    check("t5_no_tmo", 64'(tmo_seen), 64'(0));
    check("t5_grant_held", 64'(bus.gnt_o), 64'(4'b1000));
    clear_masters();
    ack_stall = 1'b0;
`endif

    // ---------------- final report ----------------
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
